// File: rtl/wave_synth_pkg.sv
// wave_synth_pkg: shared shape encoding, default duty and quarter-wave sine table
package wave_synth_pkg;

   typedef enum logic [1:0] {SQUARE, SAW, TRI, SINE} shape_e;

   // floor(127*sin(pi/2*i/64)) for i = 0..63
   localparam logic [6:0] SINE_TAB [64] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd15,  7'd18,  7'd21,
      7'd24,  7'd27,  7'd30,  7'd33,  7'd36,  7'd39,  7'd42,  7'd45,
      7'd48,  7'd51,  7'd54,  7'd57,  7'd59,  7'd62,  7'd65,  7'd67,
      7'd70,  7'd73,  7'd75,  7'd78,  7'd80,  7'd82,  7'd85,  7'd87,
      7'd89,  7'd91,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd103,
      7'd105, 7'd107, 7'd108, 7'd110, 7'd112, 7'd113, 7'd114, 7'd116,
      7'd117, 7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd123,
      7'd124, 7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd126, 7'd126
   };

   // half-scale duty used after reset
   function automatic int def_duty(input int w);
      return 1 << (w - 1);
   endfunction

   function automatic logic [6:0] sine_q(input logic [5:0] i);
      return SINE_TAB[i];
   endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// sine_quarter_rom: registered quarter-wave sine lookup
module sine_quarter_rom
   import wave_synth_pkg::*;
#(
   parameter int AW = 6,
   parameter int DW = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] data
);

   // read register doubles as the sine sample stage, holds while paused
   always_ff @(posedge clk or posedge reset)
      if (reset) data <= '0;
      else if (en) data <= DW'(sine_q(6'(addr)));

endmodule

// File: rtl/wave_synth.sv
// wave_synth: DDS waveform engine with glitch-free config and 1-bit sigma-delta output
module wave_synth
   import wave_synth_pkg::*;
#(
   parameter int ACC_W  = 24,
   parameter int SAMP_W = 8,
   parameter int LUT_AW = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ACC_W-1:0]  cfg_ftw,
   input  logic [1:0]        cfg_shape,
   input  logic [SAMP_W-1:0] cfg_duty,
   output logic [SAMP_W-1:0] sample,
   output logic              sample_valid,
   output logic              wrap,
   output logic              wave
);

   localparam logic [SAMP_W-1:0] DUTY0 = SAMP_W'(def_duty(SAMP_W));

   logic [ACC_W-1:0]  phase, ftw, sh_ftw, sum;
   shape_e            shape, sh_shape, s_shape;
   logic [SAMP_W-1:0] duty, sh_duty, s_raw, raw, coarse, tri_t, sd_acc;
   logic [SAMP_W-2:0] rom_q;
   logic [SAMP_W:0]   sd_sum;
   logic [LUT_AW-1:0] lut_a;
   logic [1:0]        quad;
   logic              carry, apply, capture, pending, s_neg;

   assign {carry, sum} = {1'b0, phase} + {1'b0, ftw};
   assign cfg_ready    = !pending;
   assign capture      = cfg_valid && !pending;
   assign apply        = pending && (carry || !enable || ftw == '0);

   // shadow capture on handshake, promote to active only at a safe point
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sh_ftw   <= '0;
         sh_shape <= SQUARE;
         sh_duty  <= DUTY0;
         ftw      <= '0;
         shape    <= SQUARE;
         duty     <= DUTY0;
         pending  <= 1'b0;
      end else begin
         if (capture) begin
            sh_ftw   <= cfg_ftw;
            sh_shape <= shape_e'(cfg_shape);
            sh_duty  <= cfg_duty;
         end
         if (apply) begin
            ftw   <= sh_ftw;
            shape <= sh_shape;
            duty  <= sh_duty;
         end
         pending <= capture || (pending && !apply);
      end

   // phase accumulator; wrap lines up with the wrapped phase value
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         phase <= '0;
         wrap  <= 1'b0;
      end else begin
         wrap <= enable && carry;
         if (enable) phase <= sum;
      end

   assign coarse = phase[ACC_W-1 -: SAMP_W];
   assign tri_t  = phase[ACC_W-2 -: SAMP_W];
   assign quad   = phase[ACC_W-1 -: 2];
   assign lut_a  = phase[ACC_W-3 -: LUT_AW];

   // non-sine shapes computed directly from the phase
   always_comb
      raw = (shape == SQUARE) ? ((coarse < duty) ? '1 : '0) :
            (shape == SAW)    ? coarse :
            phase[ACC_W-1]    ? ~tri_t : tri_t;

   sine_quarter_rom #(.AW(LUT_AW), .DW(SAMP_W-1)) u_rom (
      .clk   (clk),
      .reset (reset),
      .en    (enable),
      .addr  (quad[0] ? ~lut_a : lut_a),
      .data  (rom_q)
   );

   // pipeline register matching the ROM read latency for the other shapes
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s_raw        <= '0;
         s_shape      <= SQUARE;
         s_neg        <= 1'b0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= enable;
         if (enable) begin
            s_raw   <= raw;
            s_shape <= shape;
            s_neg   <= quad[1];
         end
      end

   // lower half-wave is 127-m, which is just the complement of 128+m
   assign sample = (s_shape == SINE) ? (s_neg ? {1'b0, ~rom_q} : {1'b1, rom_q}) : s_raw;
   assign sd_sum = {1'b0, sd_acc} + {1'b0, sample};

   // first-order sigma-delta, bypassed by a plain comparator for square
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wave   <= 1'b0;
         sd_acc <= '0;
      end else if (!enable) begin
         wave   <= 1'b0;
         sd_acc <= '0;
      end else if (s_shape == SQUARE) begin
         wave <= sample != '0;
      end else begin
         {wave, sd_acc} <= sd_sum;
      end

endmodule

// File: tb/tb_wave_synth.sv
// tb_wave_synth: directed and random checks of wave_synth against a cycle model
module tb_wave_synth;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [23:0] cfg_ftw = '0;
   logic [1:0]  cfg_shape = '0;
   logic [7:0]  cfg_duty = '0;
   logic [7:0]  sample;
   logic        sample_valid, wrap, wave;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] samp;
      logic       valid;
      logic       wrp;
      logic       wav;
      logic       rdy;
   } exp_t;

   exp_t sb[$];

   logic [23:0] m_phase, m_ftw, h_ftw;
   logic [1:0]  m_shape, h_shape, m_sshape;
   logic [7:0]  m_duty, h_duty, m_samp, m_sd;
   logic        m_pend, m_wave;

   int sine_seq[4] = '{128, 254, 127, 1};

   wave_synth #(.ACC_W(24), .SAMP_W(8), .LUT_AW(6)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_ftw      (cfg_ftw),
      .cfg_shape    (cfg_shape),
      .cfg_duty     (cfg_duty),
      .sample       (sample),
      .sample_valid (sample_valid),
      .wrap         (wrap),
      .wave         (wave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_sample(input logic [23:0] p, input logic [1:0] sh, input logic [7:0] d);
      int a, m;
      case (sh)
         2'd0: return (p[23:16] < d) ? 8'd255 : 8'd0;
         2'd1: return p[23:16];
         2'd2: return p[23] ? ~p[22:15] : p[22:15];
         default: begin
            a = int'(p[21:16]);
            if (p[22]) a = 63 - a;
            m = int'($floor(127.0 * $sin(3.14159265358979 * a / 128.0)));
            return p[23] ? 8'(127 - m) : 8'(128 + m);
         end
      endcase
   endfunction

   task automatic mdl_reset();
      m_phase = '0; m_ftw = '0; h_ftw = '0;
      m_shape = '0; h_shape = '0; m_sshape = '0;
      m_duty = 8'd128; h_duty = 8'd128;
      m_samp = '0; m_sd = '0; m_pend = 1'b0; m_wave = 1'b0;
      sb.delete();
   endtask

   // advance the model one clock, push expectations, then compare after the edge
   task automatic step();
      logic [24:0] s;
      logic        c, ap, cap, nw;
      logic [7:0]  nsd;
      exp_t        e;
      s   = {1'b0, m_phase} + {1'b0, m_ftw};
      c   = enable && s[24];
      ap  = m_pend && (c || !enable || m_ftw == 0);
      cap = cfg_valid && !m_pend;
      nw  = m_wave;
      nsd = m_sd;
      if (!enable) begin
         nw = 1'b0;
         nsd = '0;
      end else if (m_sshape == 2'd0) nw = (m_samp != 0);
      else {nw, nsd} = {1'b0, m_sd} + {1'b0, m_samp};
      if (enable) begin
         m_samp = ref_sample(m_phase, m_shape, m_duty);
         m_sshape = m_shape;
         m_phase = s[23:0];
      end
      if (ap) begin
         m_ftw = h_ftw; m_shape = h_shape; m_duty = h_duty; m_pend = 1'b0;
      end
      if (cap) begin
         h_ftw = cfg_ftw; h_shape = cfg_shape; h_duty = cfg_duty; m_pend = 1'b1;
      end
      m_wave = nw;
      m_sd = nsd;
      sb.push_back('{m_samp, enable, c, nw, !m_pend});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sample", sample, e.samp);
      chk("sample_valid", sample_valid, e.valid);
      chk("wrap", wrap, e.wrp);
      chk("wave", wave, e.wav);
      chk("cfg_ready", cfg_ready, e.rdy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_sample", sample, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_wave", wave, 0);
      chk("rst_ready", cfg_ready, 1);
      enable = 1'b0;
      cfg_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      mdl_reset();
   endtask

   task automatic offer(input logic [23:0] f, input logic [1:0] sh, input logic [7:0] d);
      cfg_ftw = f; cfg_shape = sh; cfg_duty = d; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
   endtask

   initial begin
      int k, highs, wraps, bad;
      mdl_reset();
      // square 16-cycle period, half duty
      do_reset();
      offer(24'h100000, 2'd0, 8'd128);
      chk("sq_ready_low", cfg_ready, 0);
      step();
      enable = 1'b1;
      highs = 0; wraps = 0;
      for (int n = 1; n <= 64; n++) begin
         step();
         if (n == 1) chk("sq_wave_first", wave, 0);
         if (n == 2) chk("sq_wave_rise", wave, 1);
         highs += int'(wave);
         wraps += int'(wrap);
      end
      chk("sq_highs", highs, 32);
      chk("sq_wraps", wraps, 4);
      // handshake mid-period, second offer while pending is dropped
      for (int n = 0; n < 8; n++) step();
      offer(24'h040000, 2'd0, 8'd128);
      chk("hs_ready_drop", cfg_ready, 0);
      offer(24'h020000, 2'd1, 8'd10);
      k = 0;
      do begin step(); k++; end while (!wrap && k < 40);
      chk("hs_apply_wrap", wrap, 1);
      chk("hs_ready_rise", cfg_ready, 1);
      k = 0;
      do begin step(); k++; end while (!wrap && k < 200);
      chk("hs_new_period", k, 64);
      // async reset with a pending config
      for (int n = 0; n < 5; n++) step();
      offer(24'h100000, 2'd1, 8'd128);
      for (int n = 0; n < 10; n++) step();
      chk("ar_pending", cfg_ready, 0);
      do_reset();
      enable = 1'b1;
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         step();
         if (sample !== 8'd255 || wrap) bad++;
      end
      chk("ar_static", bad, 0);
      // saw ramp one code per cycle
      do_reset();
      offer(24'h010000, 2'd1, 8'd0);
      step();
      enable = 1'b1;
      for (int n = 1; n <= 300; n++) begin
         step();
         if (n == 1 || n == 2 || n == 256 || n == 257 || n == 300) chk("saw_ramp", sample, (n - 1) % 256);
      end
      // sine quadrant starts
      do_reset();
      offer(24'h400000, 2'd3, 8'd128);
      step();
      enable = 1'b1;
      for (int n = 0; n < 8; n++) begin
         step();
         chk("sine_seq", sample, sine_seq[n % 4]);
      end
      // sigma-delta on a frozen triangle sample of 64
      do_reset();
      offer(24'h200000, 2'd1, 8'd128);
      step();
      enable = 1'b1;
      step();
      enable = 1'b0;
      offer(24'h000000, 2'd2, 8'd128);
      step();
      enable = 1'b1;
      step();
      step();
      chk("sd_level", sample, 64);
      highs = 0;
      for (int n = 0; n < 256; n++) begin
         step();
         highs += int'(wave);
      end
      chk("sd_highs", highs, 64);
      // duty boundaries
      do_reset();
      offer(24'h010000, 2'd0, 8'd0);
      step();
      enable = 1'b1;
      bad = 0;
      for (int n = 0; n < 260; n++) begin
         step();
         if (sample != 0) bad++;
      end
      chk("duty0_nonzero", bad, 0);
      do_reset();
      offer(24'h010000, 2'd0, 8'd255);
      step();
      enable = 1'b1;
      bad = 0;
      for (int n = 0; n < 256; n++) begin
         step();
         if (sample == 0) bad++;
      end
      chk("duty255_zeros", bad, 1);
      // random enables and config offers against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         enable = ($urandom_range(0, 9) != 0);
         cfg_valid = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 4))
            0: cfg_ftw = 24'h010000;
            1: cfg_ftw = 24'h040000;
            2: cfg_ftw = 24'h000000;
            default: cfg_ftw = 24'($urandom_range(0, 32'h00FFFFFF));
         endcase
         cfg_shape = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: cfg_duty = 8'd0;
            1: cfg_duty = 8'd255;
            2: cfg_duty = 8'd128;
            default: cfg_duty = 8'($urandom_range(0, 255));
         endcase
         step();
      end
      cfg_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wave_synth.md
Name: wave_synth

Overview:
- Waveform engine clocked by the 25 kHz PLL-derived clock; drives the single-bit `wave` pin at the top level.
- Uses a phase accumulator (DDS) to produce one of four shapes as a SAMP_W-bit sample.
- Converts the sample to a 1-bit output with a first-order sigma-delta modulator, or a direct comparator for square.
- New configuration is accepted by a valid/ready handshake and applied only at phase wrap, so shape and frequency changes are glitch-free.

Parameters:
- ACC_W, 24: phase accumulator width.
- SAMP_W, 8: sample and duty width.
- LUT_AW, 6: quarter-wave sine ROM address width (64 entries).

Ports:
- clk  in  1  system clock (25 kHz PLL output).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run/hold.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  shadow register free.
- cfg_ftw  in  ACC_W  frequency tuning word.
- cfg_shape  in  2  0 square, 1 saw, 2 triangle, 3 sine.
- cfg_duty  in  SAMP_W  square duty threshold.
- sample  out  SAMP_W  current unsigned sample.
- sample_valid  out  1  high when sample reflects a running phase.
- wrap  out  1  one-cycle pulse on accumulator carry.
- wave  out  1  modulated output.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is asynchronous and active-high.
- Reset values:
  - phase=0, active ftw=0, shape=0, duty=2^(SAMP_W-1).
  - pending=0, cfg_ready=1.
  - sample=0, sample_valid=0, wrap=0, wave=0, sd_acc=0.
  - Reset asserted mid-operation clears everything immediately, including any pending config.
- Phase accumulator:
  - When enable=1: phase <= phase + ftw (mod 2^ACC_W).
  - wrap <= carry-out of that add, registered, so it is coincident with the wrapped phase value.
  - When enable=0: phase holds and wrap=0.
- Config handshake:
  - cfg_ready = !pending.
  - On cfg_valid & cfg_ready: capture ftw/shape/duty into shadow and set pending=1.
  - While pending=1, cfg_valid is ignored.
- Config apply. Active config <= shadow and pending <= 0 in the cycle when pending was already 1 and any of the following holds:
  - the add carries (enable=1), or
  - enable=0, or
  - active ftw==0.
- Config corner cases:
  - A capture and a carry in the same cycle: the capture waits for the next carry.
  - Phase is never reset by an apply.
- Sample stage (registered, 1 cycle after phase). Let p = phase.
  - Square: MAX if p[ACC_W-1 -: SAMP_W] < duty, else 0.
    - duty=0 gives a constant 0.
    - duty=2^SAMP_W-1 gives high for all but one sample code.
  - Saw: p[ACC_W-1 -: SAMP_W].
  - Triangle: t = p[ACC_W-2 -: SAMP_W]; output t when p[MSB]=0, else ~t.
  - Sine:
    - q = p[ACC_W-1:ACC_W-2]; a = p[ACC_W-3 -: LUT_AW].
    - Address a when q is 0 or 2, ~a when q is 1 or 3.
    - ROM m(i) = floor(127*sin(pi/2*i/64)).
    - Output 128+m when q<2, else 127-m.
  - sample_valid <= enable.
  - When enable=0, sample holds.
- Modulator (registered, 1 cycle after sample):
  - Square shape: wave = (sample != 0).
  - Other shapes:
    - {c, sd_acc} = sd_acc + sample, with SAMP_W+1 bit add; wave <= c.
    - Long-run duty = sample/2^SAMP_W.
  - When enable=0: wave <= 0 and sd_acc <= 0.
- Latency: phase → sample 1 cycle; sample → wave 1 cycle.

Decomposition:
- wave_synth_pkg:
  - shape_e enum: SQUARE, SAW, TRI, SINE.
  - Default-duty constant.
  - Function generating the quarter-wave ROM contents.
- Sub-module sine_quarter_rom (registered read, LUT_AW → SAMP_W-1 bits). Its registered read forms the sample stage for sine; the other shapes are matched with an equal pipeline register.

Test Plan:
1. Square, ftw=2^20, duty=128, enable=1 after reset: period 16 cycles, wave high 8 / low 8, first rising edge 2 cycles after phase 0; wrap pulses every 16 cycles.
2. Saw, ftw=2^16: sample increments 0,1,2…255 then 0, one step per cycle; sample_valid=1 throughout.
3. Sine, ftw=2^22: sample sequence 128, 254, 127, 1 repeating, i.e. quadrant starts with mirrored/negated ROM.
4. Sigma-delta: saw→triangle; hold sample 64 by disabling then freezing ftw=0 with shape tri: wave high in exactly 64 of 256 cycles.
5. Handshake: offer ftw=2^18 mid-period of ftw=2^20:
   - cfg_ready drops next cycle.
   - Old frequency continues until the next wrap, then the new period of 64 cycles applies.
   - cfg_ready rises the cycle after the apply.
   - A second offer while pending is ignored.
6. Asynchronous reset asserted mid-period with pending config: all outputs return to reset values without a clock edge; after release, the pending config is discarded (active ftw=0, phase static).
